cskipa36_accum: RTL

CSKIPA36_ACCUM -- requirements
Module: cskipa36_accum

---
 rtl/cskipa36_accum.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cskipa36_accum.sv
// cskipa36_accum: framed accumulator built around a 36-bit carry-skip adder.
// Terms arriving on a valid/ready handshake are summed into a frame of up to
// FRAME_LEN terms. The frame result (sum, carry-out count, term count) is then
// offered on a second valid/ready handshake.
//
// Ports:
//   i_clk        single clock; all state updates on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_valid      upstream term valid
//   o_ready      block can accept a term (IDLE/ACCUM)
//   i_add_term   term to accumulate
//   i_flush      close the current partial frame early (ACCUM only)
//   i_clear      abandon the current frame and return to IDLE
//   o_valid      frame result valid (OUT only)
//   i_ready      downstream accepts the result
//   o_sum        frame sum modulo 2^WIDTH
//   o_carry_cnt  adder carry-outs seen in the frame, saturating at 255
//   o_count      number of terms in the frame

// CSkipA_36bit: 36-bit carry-skip adder with nine 4-bit ripple blocks.
// A block whose bits all propagate forwards its carry-in directly.
module CSkipA_36bit (
  input  logic [35:0] term1,
  input  logic [35:0] term2,
  output logic [35:0] sum,
  output logic        cout
);

  logic       c_s;
  logic       blk_in_s;
  logic [3:0] p_s;

  // Ripple within each block; skip the block when every bit propagates.
  always_comb begin
    sum      = 36'd0;
    c_s      = 1'b0;
    blk_in_s = 1'b0;
    p_s      = 4'd0;
    for (int b = 0; b < 9; b++) begin
      blk_in_s = c_s;
      for (int i = 0; i < 4; i++) begin
        p_s[i]         = term1[4*b+i] ^ term2[4*b+i];
        sum[4*b+i]     = p_s[i] ^ c_s;
        c_s            = (term1[4*b+i] & term2[4*b+i]) | (p_s[i] & c_s);
      end
      if (&p_s) begin
        c_s = blk_in_s;
      end else begin
        c_s = c_s;
      end
    end
    cout = c_s;
  end

endmodule

module cskipa36_accum #(
  parameter int WIDTH     = 36,
  parameter int FRAME_LEN = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term,
  input  logic             i_flush,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic [7:0]       o_carry_cnt,
  output logic [7:0]       o_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [7:0]       count_r, count_s;
  logic [7:0]       carry_r, carry_s;

  logic [35:0]      add_sum_s;
  logic             add_cout_s;
  logic [36:0]      add_full_s;
  logic             carry_out_s;
  logic [7:0]       carry_inc_s;
  logic             xfer_s;

  CSkipA_36bit u_adder (
    .term1 (36'(acc_r)),
    .term2 (36'(i_add_term)),
    .sum   (add_sum_s),
    .cout  (add_cout_s)
  );

  // For WIDTH below 36 the carry out of the frame width is the next sum bit.
  assign add_full_s  = {add_cout_s, add_sum_s};
  assign carry_out_s = add_full_s[WIDTH];
  assign carry_inc_s = (carry_out_s && (carry_r != 8'hFF)) ? carry_r + 8'd1 : carry_r;

  assign o_ready     = (state_r != OUT);
  assign o_valid     = (state_r == OUT);
  assign o_sum       = acc_r;
  assign o_carry_cnt = carry_r;
  assign o_count     = count_r;
  assign xfer_s      = i_valid && o_ready;

  // Next-state and datapath update; i_clear overrides everything but reset.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    count_s = count_r;
    carry_s = carry_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          acc_s   = add_sum_s[WIDTH-1:0];
          count_s = 8'd1;
          carry_s = carry_inc_s;
          state_s = ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (xfer_s) begin
          acc_s   = add_sum_s[WIDTH-1:0];
          count_s = count_r + 8'd1;
          carry_s = carry_inc_s;
          if (((count_r + 8'd1) == FRAME_LEN_C) || i_flush) begin
            state_s = OUT;
          end else begin
            state_s = ACCUM;
          end
        end else if (i_flush) begin
          // ACCUM always holds at least one term, so the flush is legal.
          state_s = OUT;
        end else begin
          state_s = ACCUM;
        end
      end
      OUT: begin
        if (i_ready) begin
          state_s = IDLE;
          acc_s   = '0;
          count_s = 8'd0;
          carry_s = 8'd0;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = '0;
        count_s = 8'd0;
        carry_s = 8'd0;
      end
    endcase
    if (i_clear) begin
      state_s = IDLE;
      acc_s   = '0;
      count_s = 8'd0;
      carry_s = 8'd0;
    end else begin
      state_s = state_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      acc_r   <= '0;
      count_r <= 8'd0;
      carry_r <= 8'd0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      count_r <= count_s;
      carry_r <= carry_s;
    end
  end

endmodule
